mat_mac_seq: RTL and testbench

Sequential, parametrised matrix-multiply accelerator; the successor to the combinational N×N multiply core. It computes C = A·B, or C = C + A·B in accumulate mode, with a single time-shared multiply-accumulate unit. Operands are captured on a start/done handshake, and the signed/unsigned mode is selectable per run. It sits behind the accelerator top level and presents flattened operand and result arrays.

---
 rtl/acc_pkg.sv | 22 ++
 rtl/mac_unit.sv | 35 +++
 rtl/mat_mac_seq.sv | 146 ++++++++++++++
 tb/tb_mat_mac_seq.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and helpers for the sequential matrix-multiply accelerator.
//   acc_state_e   : controller state encoding (IDLE, MAC, DONE)
//   acc_w_default : default result width, 2*DAT_W + clog2(N)
//   idx           : row-major element index r*n + c
package acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } acc_state_e;

  function automatic int unsigned acc_w_default(input int unsigned dat_w, input int unsigned n);
    return 2 * dat_w + $clog2(n);
  endfunction

  function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                      input int unsigned n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Combinational multiply-accumulate: sum = addend + ext(a * b), modulo 2^ACC_W.
//   a, b        in  DAT_W  operands
//   addend      in  ACC_W  value the product is added to
//   signed_mode in  1      1: two's complement operands, 0: unsigned
//   sum         out ACC_W  result
module mac_unit
  import acc_pkg::*;
#(
  parameter int unsigned DAT_W = 8,
  parameter int unsigned ACC_W = acc_w_default(8, 3)
) (
  input  logic [DAT_W-1:0] a,
  input  logic [DAT_W-1:0] b,
  input  logic [ACC_W-1:0] addend,
  input  logic             signed_mode,
  output logic [ACC_W-1:0] sum
);

  localparam int unsigned PW = 2 * DAT_W;

  logic [PW-1:0]    w_a_ext;
  logic [PW-1:0]    w_b_ext;
  logic [PW-1:0]    w_prod;
  logic [ACC_W-1:0] w_prod_ext;

  always_comb begin
    w_a_ext    = {{DAT_W{signed_mode & a[DAT_W-1]}}, a};
    w_b_ext    = {{DAT_W{signed_mode & b[DAT_W-1]}}, b};
    // Low PW bits of the product of extended operands are correct for both modes.
    w_prod     = w_a_ext * w_b_ext;
    w_prod_ext = {{(ACC_W - PW){signed_mode & w_prod[PW-1]}}, w_prod};
    sum        = addend + w_prod_ext;
  end

endmodule

// File: rtl/mat_mac_seq.sv
// Sequential N x N matrix multiply, C = A*B or C += A*B, one MAC per cycle.
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 run request, sampled only in IDLE
//   accumulate            1: C += A*B, 0: C = A*B (sampled with start)
//   signed_mode           1: signed operands, 0: unsigned (sampled with start)
//   mat_a, mat_b          row-major operands, captured on the start edge
//   busy                  high in MAC
//   done                  one-cycle pulse when C is complete
//   mat_c                 row-major registered result
module mat_mac_seq
  import acc_pkg::*;
#(
  parameter int unsigned DAT_W = 8,
  parameter int unsigned N     = 3,
  parameter int unsigned ACC_W = acc_w_default(DAT_W, N)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        accumulate,
  input  logic                        signed_mode,
  input  logic [N*N-1:0][DAT_W-1:0]   mat_a,
  input  logic [N*N-1:0][DAT_W-1:0]   mat_b,
  output logic                        busy,
  output logic                        done,
  output logic [N*N-1:0][ACC_W-1:0]   mat_c
);

  localparam int unsigned CNT_W = $clog2(N);
  localparam int unsigned IDX_W = $clog2(N * N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  acc_state_e r_state, w_state_next;

  logic [N*N-1:0][DAT_W-1:0] r_a, r_b;
  logic [N*N-1:0][ACC_W-1:0] r_c;
  logic                      r_acc, r_signed;
  logic [CNT_W-1:0]          r_i, r_j, r_k;
  logic [CNT_W-1:0]          w_i_next, w_j_next, w_k_next;
  logic [ACC_W-1:0]          r_sum;

  logic             w_last_k, w_last;
  logic [IDX_W-1:0] w_a_idx, w_b_idx, w_c_idx;
  logic [ACC_W-1:0] w_base, w_addend, w_sum;

  assign w_last_k = (r_k == LAST);
  assign w_last   = w_last_k && (r_j == LAST) && (r_i == LAST);

  assign w_a_idx = IDX_W'(idx(32'(r_i), 32'(r_k), N));
  assign w_b_idx = IDX_W'(idx(32'(r_k), 32'(r_j), N));
  assign w_c_idx = IDX_W'(idx(32'(r_i), 32'(r_j), N));

  // First product of an element starts from the old C value (accumulate) or zero.
  assign w_base   = r_acc ? r_c[w_c_idx] : '0;
  assign w_addend = (r_k == '0) ? w_base : r_sum;

  mac_unit #(
    .DAT_W (DAT_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .a           (r_a[w_a_idx]),
    .b           (r_b[w_b_idx]),
    .addend      (w_addend),
    .signed_mode (r_signed),
    .sum         (w_sum)
  );

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      IDLE: if (start) w_state_next = MAC;
      MAC: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // k innermost, then j, then i; counters sit at zero outside MAC.
  always_comb begin
    w_i_next = r_i;
    w_j_next = r_j;
    w_k_next = r_k;
    if (r_state != MAC) begin
      w_i_next = '0;
      w_j_next = '0;
      w_k_next = '0;
    end else if (!w_last_k) begin
      w_k_next = r_k + 1'b1;
    end else begin
      w_k_next = '0;
      if (r_j != LAST) begin
        w_j_next = r_j + 1'b1;
      end else begin
        w_j_next = '0;
        w_i_next = (r_i == LAST) ? '0 : r_i + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_acc    <= 1'b0;
      r_signed <= 1'b0;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_sum    <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_a      <= mat_a;
        r_b      <= mat_b;
        r_acc    <= accumulate;
        r_signed <= signed_mode;
      end
      if (r_state == MAC) begin
        r_sum <= w_sum;
        if (w_last_k) r_c[w_c_idx] <= w_sum;
      end
      r_i <= w_i_next;
      r_j <= w_j_next;
      r_k <= w_k_next;
    end
  end

  assign mat_c = r_c;

endmodule

// File: tb/tb_mat_mac_seq.sv
module tb_mat_mac_seq;

  localparam int unsigned DAT_W = 8;
  localparam int unsigned N     = 3;
  localparam int unsigned NN    = N * N;
  localparam int unsigned ACC_W = 18;
  localparam int          RUN   = N * N * N;

  typedef logic [NN-1:0][DAT_W-1:0] mat_in_t;
  typedef logic [NN-1:0][ACC_W-1:0] mat_out_t;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     start;
  logic     accumulate;
  logic     signed_mode;
  mat_in_t  mat_a;
  mat_in_t  mat_b;
  logic     busy;
  logic     done;
  mat_out_t mat_c;

  int       n_tests = 0;
  int       n_fail  = 0;
  mat_out_t exp_q[$];
  mat_out_t model_c;

  always #5 clk = ~clk;

  mat_mac_seq #(
    .DAT_W (DAT_W),
    .N     (N),
    .ACC_W (ACC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .accumulate  (accumulate),
    .signed_mode (signed_mode),
    .mat_a       (mat_a),
    .mat_b       (mat_b),
    .busy        (busy),
    .done        (done),
    .mat_c       (mat_c)
  );

  // Reference: plain integer matrix product, wrapped to ACC_W.
  function automatic mat_out_t model(input mat_in_t a, input mat_in_t b, input bit acc,
                                     input bit sm, input mat_out_t prev);
    mat_out_t r;
    longint   s, av, bv;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = acc ? longint'(prev[i*N+j]) : 64'sd0;
        for (int k = 0; k < N; k++) begin
          av = sm ? longint'($signed(a[i*N+k])) : longint'(a[i*N+k]);
          bv = sm ? longint'($signed(b[k*N+j])) : longint'(b[k*N+j]);
          s += av * bv;
        end
        r[i*N+j] = s[ACC_W-1:0];
      end
    end
    return r;
  endfunction

  function automatic mat_in_t ident();
    mat_in_t r;
    for (int e = 0; e < NN; e++) r[e] = ((e / N) == (e % N)) ? 8'd1 : 8'd0;
    return r;
  endfunction

  function automatic mat_in_t seq();
    mat_in_t r;
    for (int e = 0; e < NN; e++) r[e] = DAT_W'(e + 1);
    return r;
  endfunction

  function automatic mat_in_t fill(input logic [DAT_W-1:0] v);
    mat_in_t r;
    for (int e = 0; e < NN; e++) r[e] = v;
    return r;
  endfunction

  function automatic mat_out_t seq_c();
    mat_out_t r;
    for (int e = 0; e < NN; e++) r[e] = ACC_W'(e + 1);
    return r;
  endfunction

  function automatic mat_out_t fill_c(input logic [ACC_W-1:0] v);
    mat_out_t r;
    for (int e = 0; e < NN; e++) r[e] = v;
    return r;
  endfunction

  task automatic drive_start(input mat_in_t a, input mat_in_t b, input bit acc, input bit sm);
    mat_out_t e;
    @(negedge clk);
    mat_a       = a;
    mat_b       = b;
    accumulate  = acc;
    signed_mode = sm;
    start       = 1'b1;
    e           = model(a, b, acc, sm, model_c);
    exp_q.push_back(e);
    model_c     = e;
  endtask

  // Returns at the first sample with done high; cycles counts samples after the start edge.
  // Operands are scrambled right after the start edge to show they were captured.
  task automatic wait_done(output int cycles, output int busy_cnt, output bit timed_out);
    @(negedge clk);
    start    = 1'b0;
    mat_a    = ~mat_a;
    mat_b    = mat_in_t'({$urandom(), $urandom(), $urandom()});
    cycles   = 0;
    busy_cnt = 0;
    while (!done && cycles < 200) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    start = 1'b0; accumulate = 1'b0; signed_mode = 1'b0;
    mat_a = seq(); mat_b = seq();
    rst_n = 1'b0;
    #12;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++;
    if (mat_c !== '0) begin n_fail++; $display("FAIL reset_mat_c: got %h want 0", mat_c); end
    @(negedge clk);
    rst_n = 1'b1;
    model_c = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_identity();
    int cyc, bcnt; bit to; mat_out_t e;
    drive_start(ident(), seq(), 1'b0, 1'b0);
    wait_done(cyc, bcnt, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL identity_timeout: no done within 200 cycles"); end
    n_tests++;
    if (cyc != RUN) begin n_fail++; $display("FAIL identity_latency: got %0d want %0d", cyc, RUN); end
    n_tests++;
    if (bcnt != RUN) begin n_fail++; $display("FAIL identity_busy: got %0d want %0d", bcnt, RUN); end
    n_tests++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL identity_queue: got empty want 1"); end
    else begin
      e = exp_q.pop_front();
      if (mat_c !== e) begin n_fail++; $display("FAIL identity_result: got %h want %h", mat_c, e); end
    end
    n_tests++;
    if (mat_c !== seq_c()) begin
      n_fail++; $display("FAIL identity_const: got %h want %h", mat_c, seq_c());
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL identity_pulse: got %b want 0", done); end
  endtask

  task automatic test_unsigned_max();
    int cyc, bcnt; bit to; mat_out_t e;
    drive_start(fill(8'hFF), fill(8'hFF), 1'b0, 1'b0);
    wait_done(cyc, bcnt, to);
    n_tests++;
    if (to || exp_q.size() == 0) begin n_fail++; $display("FAIL umax_done: timeout %0d", to); end
    else begin
      e = exp_q.pop_front();
      if (mat_c !== e) begin n_fail++; $display("FAIL umax_result: got %h want %h", mat_c, e); end
    end
    n_tests++;
    if (mat_c !== fill_c(18'h2FA03)) begin
      n_fail++; $display("FAIL umax_const: got %h want all 2fa03", mat_c);
    end
  endtask

  task automatic test_signed();
    int cyc, bcnt; bit to; mat_out_t e;
    drive_start(fill(8'h80), fill(8'h80), 1'b0, 1'b1);
    wait_done(cyc, bcnt, to);
    n_tests++;
    if (to || exp_q.size() == 0) begin n_fail++; $display("FAIL s128_done: timeout %0d", to); end
    else begin
      e = exp_q.pop_front();
      if (mat_c !== e) begin n_fail++; $display("FAIL s128_result: got %h want %h", mat_c, e); end
    end
    n_tests++;
    if (mat_c !== fill_c(18'd49152)) begin
      n_fail++; $display("FAIL s128_const: got %h want all 0c000", mat_c);
    end
    drive_start(fill(8'hFF), fill(8'h01), 1'b0, 1'b1);
    wait_done(cyc, bcnt, to);
    n_tests++;
    if (to || exp_q.size() == 0) begin n_fail++; $display("FAIL sneg_done: timeout %0d", to); end
    else begin
      e = exp_q.pop_front();
      if (mat_c !== e) begin n_fail++; $display("FAIL sneg_result: got %h want %h", mat_c, e); end
    end
    n_tests++;
    if (mat_c !== fill_c(18'h3FFFD)) begin
      n_fail++; $display("FAIL sneg_const: got %h want all 3fffd", mat_c);
    end
  endtask

  task automatic test_accumulate();
    int cyc, bcnt; bit to; mat_out_t e;
    drive_start(ident(), fill(8'd2), 1'b0, 1'b0);
    wait_done(cyc, bcnt, to);
    n_tests++;
    if (to || exp_q.size() == 0) begin n_fail++; $display("FAIL acc0_done: timeout %0d", to); end
    else begin
      e = exp_q.pop_front();
      if (mat_c !== e) begin n_fail++; $display("FAIL acc0_result: got %h want %h", mat_c, e); end
    end
    drive_start(ident(), fill(8'd2), 1'b1, 1'b0);
    wait_done(cyc, bcnt, to);
    n_tests++;
    if (to || exp_q.size() == 0) begin n_fail++; $display("FAIL acc1_done: timeout %0d", to); end
    else begin
      e = exp_q.pop_front();
      if (mat_c !== e) begin n_fail++; $display("FAIL acc1_result: got %h want %h", mat_c, e); end
    end
    n_tests++;
    if (mat_c !== fill_c(18'd4)) begin
      n_fail++; $display("FAIL acc1_const: got %h want all 4", mat_c);
    end
  endtask

  task automatic test_start_while_busy();
    int done_cnt = 0, done_cyc = -1, rises = 0; logic prev_busy = 1'b1; mat_out_t e;
    drive_start(seq(), seq(), 1'b0, 1'b0);
    @(negedge clk);
    for (int c = 0; c < 45; c++) begin
      if (c > 0) @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
      start = (c == 5 || c == 27);
      mat_a = mat_in_t'({$urandom(), $urandom(), $urandom()});
    end
    start = 1'b0;
    n_tests++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL busy_done_count: got %0d want 1", done_cnt); end
    n_tests++;
    if (done_cyc != RUN) begin n_fail++; $display("FAIL busy_done_cycle: got %0d want %0d", done_cyc, RUN); end
    n_tests++;
    if (rises != 0) begin n_fail++; $display("FAIL busy_restart: got %0d want 0", rises); end
    n_tests++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL busy_queue: got empty want 1"); end
    else begin
      e = exp_q.pop_front();
      if (mat_c !== e) begin n_fail++; $display("FAIL busy_result: got %h want %h", mat_c, e); end
    end
  endtask

  task automatic test_start_held();
    int rises = 0, dones = 0; int rise_cyc[2] = '{-1, -1}; logic prev_busy = 1'b0;
    mat_out_t e;
    @(negedge clk);
    mat_a = seq(); mat_b = fill(8'd3); accumulate = 1'b0; signed_mode = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        if (rises < 2) rise_cyc[rises] = c;
        rises++;
        e = model(mat_a, mat_b, 1'b0, 1'b0, model_c);
        exp_q.push_back(e);
        model_c = e;
        if (rises == 2) start = 1'b0;
      end
      prev_busy = busy;
      if (done) begin
        dones++;
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL held_queue: got empty at cycle %0d", c); end
        else begin
          e = exp_q.pop_front();
          if (mat_c !== e) begin n_fail++; $display("FAIL held_result: got %h want %h", mat_c, e); end
        end
      end
    end
    start = 1'b0;
    n_tests++;
    if (rises != 2) begin n_fail++; $display("FAIL held_runs: got %0d want 2", rises); end
    n_tests++;
    if (dones != 2) begin n_fail++; $display("FAIL held_dones: got %0d want 2", dones); end
    n_tests++;
    if (rise_cyc[1] - rise_cyc[0] != RUN + 2) begin
      n_fail++; $display("FAIL held_period: got %0d want %0d", rise_cyc[1] - rise_cyc[0], RUN + 2);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, bcnt; bit to; mat_out_t e;
    drive_start(seq(), seq(), 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", done); end
    n_tests++;
    if (mat_c !== '0) begin n_fail++; $display("FAIL midrst_mat_c: got %h want 0", mat_c); end
    exp_q.delete();
    model_c = '0;
    @(negedge clk);
    rst_n = 1'b1;
    // Accumulating onto the cleared C must give the plain product.
    drive_start(ident(), seq(), 1'b1, 1'b0);
    wait_done(cyc, bcnt, to);
    n_tests++;
    if (to || cyc != RUN) begin n_fail++; $display("FAIL midrst_latency: got %0d want %0d", cyc, RUN); end
    n_tests++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL midrst_queue: got empty want 1"); end
    else begin
      e = exp_q.pop_front();
      if (mat_c !== e) begin n_fail++; $display("FAIL midrst_result: got %h want %h", mat_c, e); end
    end
    n_tests++;
    if (mat_c !== seq_c()) begin
      n_fail++; $display("FAIL midrst_const: got %h want %h", mat_c, seq_c());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_identity();
    test_unsigned_max();
    test_signed();
    test_accumulate();
    test_start_while_busy();
    test_start_held();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
